// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and ID.
// The queue connects through the slave modport; fetch/ID (or a bench) use master.
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [AW-1:0] in_pc;
    logic [DW-1:0] in_inst;
    logic          in_ready;
    logic          flush;
    logic          out_valid;
    logic [AW-1:0] out_pc;
    logic [DW-1:0] out_inst;
    logic          out_ready;
    logic [CW-1:0] count;

    modport slave (
        input  in_valid, in_pc, in_inst, flush, out_ready,
        output in_ready, out_valid, out_pc, out_inst, count
    );

    modport master (
        output in_valid, in_pc, in_inst, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers {pc, inst} between fetch and ID, flushed on redirect.
// Optional occupancy/flush statistics are enabled with FETCH_QUEUE_STAT_EN.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic        clk,
    input  logic        rst,
    fetch_queue_if.slave fq
`ifdef FETCH_QUEUE_STAT_EN
    ,
    output logic [31:0] full_cycles,
    output logic [31:0] flush_drops
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [DW-1:0] NOP = DW'(32'h0000_0013);

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW+DW-1:0] mem_q [DEPTH];
    logic             push, pop, full, empty;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Ready depends only on registered count, so a same-cycle pop never frees a slot.
    assign fq.in_ready  = ~full;
    assign fq.out_valid = ~empty;
    assign fq.count     = count_q;

    assign push = fq.in_valid & ~full & ~fq.flush;
    assign pop  = ~empty & fq.out_ready & ~fq.flush;

    always_comb begin
        if (empty) begin
            fq.out_pc   = '0;
            fq.out_inst = NOP;
        end else begin
            {fq.out_pc, fq.out_inst} = mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (fq.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally left unreset; out_* are masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {fq.in_pc, fq.in_inst};
    end

`ifdef FETCH_QUEUE_STAT_EN
    logic [31:0] full_cycles_q, flush_drops_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_cycles_q <= '0;
            flush_drops_q <= '0;
        end else begin
            if (full && full_cycles_q != '1)
                full_cycles_q <= full_cycles_q + 32'd1;
            if (fq.flush && !empty && flush_drops_q != '1)
                flush_drops_q <= flush_drops_q + 32'd1;
        end
    end

    assign full_cycles = full_cycles_q;
    assign flush_drops = flush_drops_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a FIFO scoreboard predicts head, occupancy and handshakes.
// Build with FETCH_QUEUE_STAT_EN to also check the statistics counters.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH), .AW(32), .DW(32)) bus ();

`ifdef FETCH_QUEUE_STAT_EN
    logic [31:0] full_cycles, flush_drops;
    logic [31:0] exp_full, exp_drops;
`endif

    fetch_queue #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (bus.slave)
`ifdef FETCH_QUEUE_STAT_EN
        ,
        .full_cycles (full_cycles),
        .flush_drops (flush_drops)
`endif
    );

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q [$];

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_5A00;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_inst   = inst_of(pc);
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    // Check the current cycle against the model, then advance model and DUT one clock.
    task automatic cycle(input string tag);
        int  n;
        logic do_push, do_pop;
        n = exp_q.size();
        chk({tag, ".count"}, 64'(bus.count), 64'(n));
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(n != DEPTH));
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(n != 0));
        if (n == 0) chk({tag, ".idle"}, {bus.out_pc, bus.out_inst}, {32'h0, 32'h0000_0013});
        else        chk({tag, ".head"}, {bus.out_pc, bus.out_inst}, exp_q[0]);
`ifdef FETCH_QUEUE_STAT_EN
        chk({tag, ".full_cycles"}, 64'(full_cycles), 64'(exp_full));
        chk({tag, ".flush_drops"}, 64'(flush_drops), 64'(exp_drops));
        if (n == DEPTH) exp_full++;
        if (bus.flush && n != 0) exp_drops++;
`endif
        if (bus.flush) begin
            exp_q.delete();
        end else begin
            do_pop  = (n != 0) && bus.out_ready;
            do_push = bus.in_valid && (n != DEPTH);
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({bus.in_pc, inst_of(bus.in_pc)});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_QUEUE_STAT_EN
        exp_full  = '0;
        exp_drops = '0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cycle("reset");

        // T2 fill, refused fifth push, then drain in order
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
            cycle("t2_fill");
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle("t2_drain");

        // T3 streaming across pointer wrap
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1, 1'b0);
            cycle("t3_stream");
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (2) cycle("t3_tail");

        // T4 flush at count 3 drops the concurrent push
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h20 + 32'(i * 4), 1'b0, 1'b0);
            cycle("t4_fill");
        end
        drive(1'b1, 32'h40, 1'b0, 1'b1);
        cycle("t4_flush");
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cycle("t4_after");
        drive(1'b1, 32'h100, 1'b1, 1'b0);
        cycle("t4_push");
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (2) cycle("t4_drain");

        // T5 full with simultaneous pop: push refused
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
            cycle("t5_fill");
        end
        drive(1'b1, 32'h999, 1'b1, 1'b0);
        cycle("t5_fullpop");
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (4) cycle("t5_drain");

        // T6 hold full, drain to 2, flush
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
            cycle("t6_fill");
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (4) cycle("t6_hold");
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (2) cycle("t6_pop");
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        cycle("t6_flush");
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cycle("t6_after");

        // T1 asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h400 + 32'(i * 4), 1'b0, 1'b0);
            cycle("t1_fill");
        end
        #2 rst = 1'b1;
        #1;
        chk("t1.out_valid", 64'(bus.out_valid), 64'(0));
        chk("t1.count", 64'(bus.count), 64'(0));
        chk("t1.in_ready", 64'(bus.in_ready), 64'(1));
        chk("t1.out_inst", 64'(bus.out_inst), 64'(32'h0000_0013));
        exp_q.delete();
`ifdef FETCH_QUEUE_STAT_EN
        exp_full  = '0;
        exp_drops = '0;
`endif
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cycle("t1_after");
        drive(1'b1, 32'h500, 1'b1, 1'b0);
        cycle("t1_push");
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (2) cycle("t1_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
